irq_vector_ctrl: RTL and testbench
==================================

IRQ_VECTOR_CTRL -- requirements
Module: irq_vector_ctrl

Interface
REQ-001 Parameter N_SRC, default 4: number of interrupt sources; legal range 1..16.
REQ-002 Parameter VEC_W, default 8: vector address width.
REQ-003 Parameter VEC_BASE, default 8'h01: vector address of source 0.
REQ-004 Parameter VEC_STRIDE, default 1: vector address spacing between consecutive sources.
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 irq_in  in  N_SRC  interrupt lines; a 0->1 transition between consecutive clk samples is a request.
REQ-008 mask_we  in  1  mask register write strobe.
REQ-009 mask_wdata  in  N_SRC  new mask value; bit=1 masks that source.
REQ-010 irq_req  out  1  interrupt request to core.
REQ-011 irq_ack  in  1  core acceptance of irq_req.
REQ-012 vec_addr  out  VEC_W  vector address of the accepted source.
REQ-013 vec_valid  out  1  one-cycle pulse; vec_addr is new.
REQ-014 reti  in  1  one-cycle return-from-interrupt strobe from core.
REQ-015 pending  out  N_SRC  pending register.
REQ-016 in_service  out  N_SRC  in-service register.

Function
REQ-017 Edge detect: prev register samples irq_in each cycle; pending[i] sets when irq_in[i] & ~prev[i].
REQ-018 Pending sets regardless of mask; the mask gates request generation only.
REQ-019 Eligible = pending & ~mask; priority is fixed, lowest index highest.
REQ-020 FSM states are IDLE, REQ and SERVICE.
REQ-021 IDLE: if any eligible bit is set, latch its index into sel, move to REQ, and assert irq_req from the next cycle.
REQ-022 REQ: hold irq_req=1 and sel frozen until irq_ack; a mask write or a higher-priority arrival does not change sel.
REQ-023 On irq_ack in REQ, in the same edge: clear pending[sel], set in_service[sel], drop irq_req, load vec_addr, pulse vec_valid for one cycle, and move to SERVICE.
REQ-024 vec_addr = (VEC_BASE + sel*VEC_STRIDE) mod 2^VEC_W; it holds its value until the next acknowledge.
REQ-025 irq_ack outside REQ is ignored.
REQ-026 A new edge on bit i in the same cycle as clearing pending[i]: the set wins and the bit stays pending.
REQ-027 SERVICE: reti clears the lowest-index set bit of in_service; when in_service becomes 0, move to IDLE.
REQ-028 reti while in_service==0 is ignored.
REQ-029 reti and irq_ack never coincide in the same state; if both are asserted in SERVICE, ack is ignored.
REQ-030 A mask write takes effect the next cycle.

Reset
REQ-031 rst asserted: state=IDLE; pending, in_service, mask, prev, sel and vec_addr all zero; irq_req=0; vec_valid=0.
REQ-032 rst mid-REQ or mid-SERVICE aborts immediately with no vec_valid pulse.
REQ-033 prev resets to 0, so a line held high across reset release registers one edge on the first clock.

Configuration
REQ-034 Macro IRQ_NEST_EN: when defined, in SERVICE an eligible source with index lower than the lowest set in_service bit moves the FSM to REQ (preemption), and in_service may hold multiple bits.
REQ-035 Nested REQ returns to SERVICE on ack.
REQ-036 Nested REQ drops irq_req when every in_service bit is cleared by reti before ack is received.
REQ-037 Without IRQ_NEST_EN, SERVICE ignores all eligible sources until in_service returns to 0, and in_service is at most one-hot.

Verification
REQ-038 N_SRC=4; pulse irq_in[2] 0->1; ack two cycles later -> irq_req rises one cycle after the edge; vec_valid pulses with vec_addr=8'h03; pending=0, in_service=4'b0100.
REQ-039 Edges on bits 3 and 1 in the same cycle -> first ack gives vec_addr=8'h02; after reti, next ack gives 8'h04.
REQ-040 mask=4'b0001, edge on bit 0 -> no irq_req, pending=4'b0001; write mask=0 -> irq_req rises on the following cycle.
REQ-041 IRQ_NEST_EN defined, in service on bit 2, edge on bit 0 -> irq_req; ack gives in_service=4'b0101; two retis return to IDLE. Without the macro, no irq_req until the first reti.
REQ-042 rst asserted while in REQ -> irq_req=0 and pending=0 immediately; irq_in held high at release -> pending[i] sets on the first clock.

Source files
------------

// File: rtl/irq_vector_ctrl.sv
// irq_vector_ctrl
//   Edge-triggered interrupt controller with fixed priority (lowest index wins)
//   and vector address generation for a single core.
//
// Optional feature macro: IRQ_NEST_EN
//   When defined, a higher-priority eligible source may preempt a source that
//   is in service, and in_service can hold several bits. When undefined,
//   in_service is at most one-hot and SERVICE ignores new requests.
//
// Ports
//   clk         in   clock, all state changes on rising edge
//   rst         in   asynchronous, active-high reset
//   irq_in      in   [N_SRC] interrupt lines, a 0->1 change between samples is a request
//   mask_we     in   mask register write strobe
//   mask_wdata  in   [N_SRC] new mask value, 1 = source masked
//   irq_req     out  interrupt request to the core
//   irq_ack     in   core acceptance of irq_req
//   vec_addr    out  [VEC_W] vector address of the last accepted source
//   vec_valid   out  one-cycle pulse when vec_addr has just been loaded
//   reti        in   return-from-interrupt strobe
//   pending     out  [N_SRC] pending register
//   in_service  out  [N_SRC] in-service register
//   o_dbg_state out  [2] current FSM state (0 IDLE, 1 REQ, 2 SERVICE)
//
// Handshake: irq_req is a valid that stays high, with the selected source
// frozen, until the cycle irq_ack is sampled high; that edge is the transfer.
// irq_ack sampled while irq_req is low is ignored.

module irq_vector_ctrl #(
  parameter int                N_SRC      = 4,
  parameter int                VEC_W      = 8,
  parameter logic [VEC_W-1:0]  VEC_BASE   = VEC_W'(1),
  parameter int                VEC_STRIDE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  output logic             irq_req,
  input  logic             irq_ack,
  output logic [VEC_W-1:0] vec_addr,
  output logic             vec_valid,
  input  logic             reti,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] in_service,
  output logic [1:0]       o_dbg_state
);

`ifdef IRQ_NEST_EN
  localparam bit NEST_EN = 1'b1;
`else
  localparam bit NEST_EN = 1'b0;
`endif

  localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t             r_state;
  logic [N_SRC-1:0]   r_prev;
  logic [N_SRC-1:0]   r_mask;
  logic [N_SRC-1:0]   r_pending;
  logic [N_SRC-1:0]   r_in_service;
  logic [SEL_W-1:0]   r_sel;
  logic               r_irq_req;
  logic [VEC_W-1:0]   r_vec_addr;
  logic               r_vec_valid;

  logic [N_SRC-1:0]   w_edge;
  logic [N_SRC-1:0]   w_elig;
  logic [SEL_W-1:0]   w_elig_idx;
  logic [N_SRC-1:0]   w_sel_onehot;
  logic               w_ack_fire;
  logic [N_SRC-1:0]   w_clr;
  logic [N_SRC-1:0]   w_isr_lowbit;
  logic [N_SRC-1:0]   w_isr_after_reti;
  logic               w_preempt;
  logic [VEC_W-1:0]   w_vec;

  // Index of the lowest set bit (highest priority); 0 when none is set.
  function automatic logic [SEL_W-1:0] f_lowest(input logic [N_SRC-1:0] v);
    f_lowest = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) f_lowest = SEL_W'(i);
    end
  endfunction

  assign w_edge       = irq_in & ~r_prev;
  assign w_elig       = r_pending & ~r_mask;
  assign w_elig_idx   = f_lowest(w_elig);
  assign w_sel_onehot = N_SRC'(1) << r_sel;
  assign w_ack_fire   = (r_state == S_REQ) && irq_ack;
  assign w_clr        = w_ack_fire ? w_sel_onehot : '0;

  // x & -x isolates the lowest set bit; reti retires that one.
  assign w_isr_lowbit     = r_in_service & (~r_in_service + N_SRC'(1));
  assign w_isr_after_reti = r_in_service & ~w_isr_lowbit;

  // Bits strictly below the lowest in-service bit outrank everything in service.
  assign w_preempt = NEST_EN && (|(w_elig & (w_isr_lowbit - N_SRC'(1))));

  // Truncation to VEC_W gives the modulo 2^VEC_W wrap.
  assign w_vec = VEC_BASE + VEC_W'(32'(r_sel) * VEC_STRIDE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_prev       <= '0;
      r_mask       <= '0;
      r_pending    <= '0;
      r_in_service <= '0;
      r_sel        <= '0;
      r_irq_req    <= 1'b0;
      r_vec_addr   <= '0;
      r_vec_valid  <= 1'b0;
    end else begin
      r_prev      <= irq_in;
      r_vec_valid <= 1'b0;
      if (mask_we) r_mask <= mask_wdata;
      // Clear first, then OR the new edges so a same-cycle edge keeps the bit pending.
      r_pending <= (r_pending & ~w_clr) | w_edge;

      case (r_state)
        S_IDLE: begin
          if (|w_elig) begin
            r_sel     <= w_elig_idx;
            r_irq_req <= 1'b1;
            r_state   <= S_REQ;
          end
        end

        S_REQ: begin
          if (irq_ack) begin
            r_in_service <= r_in_service | w_sel_onehot;
            r_irq_req    <= 1'b0;
            r_vec_addr   <= w_vec;
            r_vec_valid  <= 1'b1;
            r_state      <= S_SERVICE;
          end else if (NEST_EN && reti && (|r_in_service)) begin
            // Preempting request whose interrupted handlers all returned first.
            r_in_service <= w_isr_after_reti;
            if (~|w_isr_after_reti) begin
              r_irq_req <= 1'b0;
              r_state   <= S_IDLE;
            end
          end
        end

        S_SERVICE: begin
          if (reti) begin
            r_in_service <= w_isr_after_reti;
            if (~|w_isr_after_reti) r_state <= S_IDLE;
          end else if (w_preempt) begin
            r_sel     <= w_elig_idx;
            r_irq_req <= 1'b1;
            r_state   <= S_REQ;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign irq_req     = r_irq_req;
  assign vec_addr    = r_vec_addr;
  assign vec_valid   = r_vec_valid;
  assign pending     = r_pending;
  assign in_service  = r_in_service;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// tb_irq_vector_ctrl
//   Directed scenarios followed by random traffic for irq_vector_ctrl with
//   default parameters (N_SRC=4, VEC_W=8, VEC_BASE=1, VEC_STRIDE=1).
//   The reference model keeps the controller as three facts: which lines are
//   pending, which are in service, and whether a request is outstanding.

module tb_irq_vector_ctrl;

  localparam int TB_BASE   = 1;
  localparam int TB_STRIDE = 1;
`ifdef IRQ_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       irq_req;
  logic       irq_ack;
  logic [7:0] vec_addr;
  logic       vec_valid;
  logic       reti;
  logic [3:0] pending;
  logic [3:0] in_service;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  irq_vector_ctrl #(
    .N_SRC(4), .VEC_W(8), .VEC_BASE(8'h01), .VEC_STRIDE(1)
  ) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .irq_req(irq_req), .irq_ack(irq_ack),
    .vec_addr(vec_addr), .vec_valid(vec_valid), .reti(reti),
    .pending(pending), .in_service(in_service), .o_dbg_state(dbg_state)
  );

  // reference model
  bit [3:0] m_pend, m_isr, m_mask, m_prev;
  bit       m_req, m_vv;
  int       m_sel;
  bit [7:0] m_vec;

  function automatic int lowest(input bit [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_isr = '0; m_mask = '0; m_prev = '0;
    m_req = 1'b0; m_vv = 1'b0; m_sel = 0; m_vec = '0;
  endtask

  task automatic model_step();
    bit [3:0] e;
    bit [3:0] elig;
    int le, li;
    e    = irq_in & ~m_prev;
    elig = m_pend & ~m_mask;
    le   = lowest(elig);
    li   = lowest(m_isr);
    m_vv = 1'b0;
    if (m_req) begin
      if (irq_ack) begin
        m_pend[m_sel] = 1'b0;
        m_isr[m_sel]  = 1'b1;
        m_vec = 8'((TB_BASE + m_sel * TB_STRIDE) % 256);
        m_vv  = 1'b1;
        m_req = 1'b0;
      end else if (NEST && reti && m_isr != 0) begin
        m_isr[li] = 1'b0;
        if (m_isr == 0) m_req = 1'b0;
      end
    end else if (m_isr == 0) begin
      if (le >= 0) begin m_sel = le; m_req = 1'b1; end
    end else begin
      if (reti) m_isr[li] = 1'b0;
      else if (NEST && le >= 0 && le < li) begin m_sel = le; m_req = 1'b1; end
    end
    m_pend = m_pend | e;
    m_prev = irq_in;
    if (mask_we) m_mask = mask_wdata;
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".irq_req"},    irq_req,    m_req);
    chk({tag, ".vec_valid"},  vec_valid,  m_vv);
    chk({tag, ".vec_addr"},   vec_addr,   m_vec);
    chk({tag, ".pending"},    pending,    m_pend);
    chk({tag, ".in_service"}, in_service, m_isr);
  endtask

  // driver tasks
  task automatic tick(input string tag = "step");
    @(posedge clk);
    model_step();
    #1;
    chk_model(tag);
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; tick("ack"); irq_ack = 1'b0;
  endtask

  task automatic pulse_reti();
    reti = 1'b1; tick("reti"); reti = 1'b0;
  endtask

  task automatic wait_req();
    for (int n = 0; n < 20 && !irq_req; n++) tick("wait");
    chk("wait_irq_req", irq_req, 1'b1);
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
    irq_ack = 1'b0; reti = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.irq_req", irq_req, 1'b0);
    chk("rst.vec_valid", vec_valid, 1'b0);
    chk("rst.vec_addr", vec_addr, 8'h00);
    chk("rst.pending", pending, 4'b0000);
    chk("rst.in_service", in_service, 4'b0000);
    rst = 1'b0;
    tick("idle");

    // single source on bit 2
    irq_in = 4'b0100; tick("s2_edge");
    chk("s2.pending", pending, 4'b0100);
    chk("s2.req_low", irq_req, 1'b0);
    irq_in = 4'b0000; tick("s2_req");
    chk("s2.req_high", irq_req, 1'b1);
    tick("s2_hold");
    pulse_ack();
    chk("s2.vec_valid", vec_valid, 1'b1);
    chk("s2.vec_addr", vec_addr, 8'h03);
    chk("s2.pending0", pending, 4'b0000);
    chk("s2.isr", in_service, 4'b0100);
    tick("s2_after");
    chk("s2.vec_valid_pulse", vec_valid, 1'b0);
    pulse_reti();
    chk("s2.isr_clear", in_service, 4'b0000);

    // simultaneous edges on bits 3 and 1
    irq_in = 4'b1010; tick("dual_edge");
    irq_in = 4'b0000;
    wait_req();
    pulse_ack();
    chk("dual.vec_first", vec_addr, 8'h02);
    pulse_reti();
    wait_req();
    pulse_ack();
    chk("dual.vec_second", vec_addr, 8'h04);
    pulse_reti();

    // mask gates request but not pending
    mask_we = 1'b1; mask_wdata = 4'b0001; tick("mask_wr");
    mask_we = 1'b0; irq_in = 4'b0001; tick("mask_edge");
    irq_in = 4'b0000;
    chk("mask.pending", pending, 4'b0001);
    tick("mask_hold"); tick("mask_hold");
    chk("mask.no_req", irq_req, 1'b0);
    mask_we = 1'b1; mask_wdata = 4'b0000; tick("unmask");
    mask_we = 1'b0;
    chk("unmask.not_yet", irq_req, 1'b0);
    tick("unmask_req");
    chk("unmask.req", irq_req, 1'b1);
    pulse_ack();
    pulse_reti();

    // higher priority arrival while bit 2 is in service
    irq_in = 4'b0100; tick("nest_e2");
    irq_in = 4'b0000;
    wait_req();
    pulse_ack();
    chk("nest.isr2", in_service, 4'b0100);
    irq_in = 4'b0001; tick("nest_e0");
    irq_in = 4'b0000; tick("nest_eval");
`ifdef IRQ_NEST_EN
    chk("nest.preempt_req", irq_req, 1'b1);
    pulse_ack();
    chk("nest.isr_both", in_service, 4'b0101);
    pulse_reti();
    chk("nest.isr_after1", in_service, 4'b0100);
    pulse_reti();
    chk("nest.isr_after2", in_service, 4'b0000);
    tick("nest_idle");
    chk("nest.idle_no_req", irq_req, 1'b0);
`else
    chk("nonest.no_req", irq_req, 1'b0);
    tick("nonest_hold");
    chk("nonest.still_no_req", irq_req, 1'b0);
    pulse_reti();
    chk("nonest.isr_clear", in_service, 4'b0000);
    tick("nonest_req");
    chk("nonest.req_after_reti", irq_req, 1'b1);
    pulse_ack();
    chk("nonest.isr0", in_service, 4'b0001);
    pulse_reti();
`endif

    // asynchronous reset in REQ, line held high across release
    irq_in = 4'b0001; tick("rst_edge");
    tick("rst_req");
    chk("rstreq.req", irq_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rstreq.irq_req", irq_req, 1'b0);
    chk("rstreq.pending", pending, 4'b0000);
    chk("rstreq.vec_valid", vec_valid, 1'b0);
    model_reset();
    #2 rst = 1'b0;
    tick("rst_release");
    chk("rstrel.pending", pending, 4'b0001);
    irq_in = 4'b0000;
    wait_req();
    pulse_ack();
    pulse_reti();

    // random traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) irq_in = 4'($urandom_range(0, 15));
      irq_ack    = ($urandom_range(0, 3) == 0);
      reti       = ($urandom_range(0, 4) == 0);
      mask_we    = ($urandom_range(0, 15) == 0);
      mask_wdata = 4'($urandom_range(0, 15));
      if (c == 300) begin
        #2 rst = 1'b1;
        #1;
        chk("rand_rst.irq_req", irq_req, 1'b0);
        chk("rand_rst.in_service", in_service, 4'b0000);
        chk("rand_rst.vec_valid", vec_valid, 1'b0);
        model_reset();
        #1 rst = 1'b0;
      end
      tick("rand");
    end
    irq_ack = 1'b0; reti = 1'b0; mask_we = 1'b0;

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
